// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl
// Purpose  : Raster timing sequencer. Issues pixel fetch strobes/coordinates
//            PIX_LEAD cycles ahead of the matching blank/h_synch/v_synch.
//            Build macro SCANDOUBLE_EN repeats each source row on two lines.
// Revision : 1.0
// ============================================================================
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_LEAD = 2
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        run,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        line_repeat,
  output logic        h_synch,
  output logic        v_synch,
  output logic        blank
);

  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_last   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
  localparam logic [10:0] c_v_last   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        c_hs_off   = (HS_POL == 0);
  localparam logic        c_vs_off   = (VS_POL == 0);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t            r_state;
  logic [10:0]       r_hcount;
  logic [10:0]       r_vcount;
  logic [PIX_LEAD:0] r_blank_pipe;
  logic [PIX_LEAD:0] r_hs_pipe;
  logic [PIX_LEAD:0] r_vs_pipe;

  logic        w_advance;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_visible;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic [10:0] w_fetch_y;
  logic        w_repeat;

  assign w_advance = (r_state == ST_ACTIVE) && run;
  assign w_h_wrap  = (r_hcount == c_h_last);
  assign w_v_wrap  = (r_vcount == c_v_last);
  assign w_visible = (r_hcount < c_h_active) && (r_vcount < c_v_active);
  assign w_hs_raw  = (r_hcount >= c_hs_start) && (r_hcount < c_hs_end);
  assign w_vs_raw  = (r_vcount >= c_vs_start) && (r_vcount < c_vs_end);

`ifdef SCANDOUBLE_EN
  assign w_fetch_y = {1'b0, r_vcount[10:1]};
  assign w_repeat  = r_vcount[0];
`else
  assign w_fetch_y = r_vcount;
  assign w_repeat  = 1'b0;
`endif

  // Idle and reset share one path: counters at origin, fetch quiet, display
  // pipeline refilled with blank/inactive-sync so no stale pixel is shown.
  always_ff @(posedge pixel_clock) begin
    if (reset || !w_advance) begin
      r_state      <= (!reset && run) ? ST_ACTIVE : ST_IDLE;
      r_hcount     <= '0;
      r_vcount     <= '0;
      pix_req      <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      line_repeat  <= 1'b0;
      r_blank_pipe <= '1;
      r_hs_pipe    <= {(PIX_LEAD + 1){c_hs_off}};
      r_vs_pipe    <= {(PIX_LEAD + 1){c_vs_off}};
    end else begin
      r_state  <= ST_ACTIVE;
      r_hcount <= w_h_wrap ? 11'd0 : r_hcount + 11'd1;
      if (w_h_wrap) begin
        r_vcount <= w_v_wrap ? 11'd0 : r_vcount + 11'd1;
      end
      pix_req <= w_visible;
      if (w_visible) begin
        pix_x <= r_hcount;
        pix_y <= w_fetch_y;
      end
      line_start   <= (r_hcount == 11'd0);
      frame_start  <= (r_hcount == 11'd0) && (r_vcount == 11'd0);
      line_repeat  <= w_repeat;
      r_blank_pipe <= {r_blank_pipe[PIX_LEAD-1:0], ~w_visible};
      r_hs_pipe    <= {r_hs_pipe[PIX_LEAD-1:0], w_hs_raw ^ c_hs_off};
      r_vs_pipe    <= {r_vs_pipe[PIX_LEAD-1:0], w_vs_raw ^ c_vs_off};
    end
  end

  assign blank   = r_blank_pipe[PIX_LEAD];
  assign h_synch = r_hs_pipe[PIX_LEAD];
  assign v_synch = r_vs_pipe[PIX_LEAD];

endmodule
`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_ctrl
// Purpose  : Directed bench: default 640x480 raster plus a tiny raster instance
//            for whole-frame behaviour. Honours SCANDOUBLE_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_video_timing_ctrl;

`ifdef SCANDOUBLE_EN
  localparam bit c_sd = 1'b1;
`else
  localparam bit c_sd = 1'b0;
`endif

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic        run;
  logic        run_s;

  logic        d_pix_req, d_line_start, d_frame_start, d_line_repeat;
  logic        d_h_synch, d_v_synch, d_blank;
  logic [10:0] d_pix_x, d_pix_y;
  logic        s_pix_req, s_line_start, s_frame_start, s_line_repeat;
  logic        s_h_synch, s_v_synch, s_blank;
  logic [10:0] s_pix_x, s_pix_y;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 pixel_clock = ~pixel_clock;

  video_timing_ctrl u_dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .run         (run),
    .pix_req     (d_pix_req),
    .pix_x       (d_pix_x),
    .pix_y       (d_pix_y),
    .line_start  (d_line_start),
    .frame_start (d_frame_start),
    .line_repeat (d_line_repeat),
    .h_synch     (d_h_synch),
    .v_synch     (d_v_synch),
    .blank       (d_blank)
  );

  // 16 x 12 raster, active-high hsync, 3-cycle lead
  video_timing_ctrl #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
    .HS_POL (1), .VS_POL (0), .PIX_LEAD (3)
  ) u_small (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .run         (run_s),
    .pix_req     (s_pix_req),
    .pix_x       (s_pix_x),
    .pix_y       (s_pix_y),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .line_repeat (s_line_repeat),
    .h_synch     (s_h_synch),
    .v_synch     (s_v_synch),
    .blank       (s_blank)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge pixel_clock);
    cyc = cyc + n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int hs_low, hs_first, ls_seen, blank_ones;
  int fs_cnt, fs_first, req_cnt, vs_low, vs_first, hs_high, blank_low, row;

  initial begin
    reset = 1'b1; run = 1'b0; run_s = 1'b0;
    tick(4);
    chk("rst_pix_req",  32'(d_pix_req), 0);
    chk("rst_pix_x",    32'(d_pix_x), 0);
    chk("rst_pix_y",    32'(d_pix_y), 0);
    chk("rst_line_st",  32'(d_line_start), 0);
    chk("rst_frame_st", 32'(d_frame_start), 0);
    chk("rst_line_rep", 32'(d_line_repeat), 0);
    chk("rst_blank",    32'(d_blank), 1);
    chk("rst_hsync",    32'(d_h_synch), 1);
    chk("rst_vsync",    32'(d_v_synch), 1);
    chk("rst_s_hsync",  32'(s_h_synch), 0);
    chk("rst_s_vsync",  32'(s_v_synch), 1);
    chk("rst_s_blank",  32'(s_blank), 1);

    // Start of raster: cyc counts cycles after the edge that samples run=1
    reset = 1'b0; run = 1'b1; cyc = -1;
    tick(1);
    chk("c0_pix_req", 32'(d_pix_req), 0);
    chk("c0_blank",   32'(d_blank), 1);
    tick(1);
    chk("c1_pix_req",  32'(d_pix_req), 1);
    chk("c1_pix_x",    32'(d_pix_x), 0);
    chk("c1_pix_y",    32'(d_pix_y), 0);
    chk("c1_frame_st", 32'(d_frame_start), 1);
    chk("c1_line_st",  32'(d_line_start), 1);
    chk("c1_blank",    32'(d_blank), 1);
    tick(1);
    chk("c2_blank",    32'(d_blank), 1);
    chk("c2_frame_st", 32'(d_frame_start), 0);
    tick(1);
    chk("c3_blank", 32'(d_blank), 0);
    chk("c3_pix_x", 32'(d_pix_x), 2);
    tick(637);
    chk("c640_pix_x",   32'(d_pix_x), 639);
    chk("c640_pix_req", 32'(d_pix_req), 1);
    tick(1);
    chk("c641_pix_req", 32'(d_pix_req), 0);
    chk("c641_pix_x",   32'(d_pix_x), 639);
    tick(1);
    chk("c642_blank", 32'(d_blank), 0);
    tick(1);
    chk("c643_blank", 32'(d_blank), 1);

    hs_low = 0; hs_first = 0; ls_seen = 0;
    for (int i = 0; i < 157; i++) begin
      tick(1);
      if (d_h_synch === 1'b0) begin
        if (hs_low == 0) hs_first = cyc;
        hs_low = hs_low + 1;
      end
      if (d_line_start === 1'b1) ls_seen = ls_seen + 1;
    end
    chk("hs_width",       32'(hs_low), 96);
    chk("hs_fall_cycle",  32'(hs_first), 659);
    chk("no_early_line",  32'(ls_seen), 0);
    tick(1);
    chk("c801_line_st",   32'(d_line_start), 1);
    chk("c801_pix_x",     32'(d_pix_x), 0);
    chk("c801_pix_y",     32'(d_pix_y), c_sd ? 0 : 1);
    chk("c801_line_rep",  32'(d_line_repeat), c_sd ? 1 : 0);
    tick(2);
    chk("c803_blank",     32'(d_blank), 0);

    // Drop run at hcount=300 of line 1
    tick(297);
    chk("c1100_pix_req", 32'(d_pix_req), 1);
    chk("c1100_pix_x",   32'(d_pix_x), 299);
    chk("c1100_blank",   32'(d_blank), 0);
    run = 1'b0;
    tick(3);
    chk("stop_pix_req", 32'(d_pix_req), 0);
    chk("stop_blank",   32'(d_blank), 1);
    chk("stop_hsync",   32'(d_h_synch), 1);
    tick(2);
    run = 1'b1; cyc = -1;
    tick(2);
    chk("rs_pix_req",  32'(d_pix_req), 1);
    chk("rs_pix_x",    32'(d_pix_x), 0);
    chk("rs_pix_y",    32'(d_pix_y), 0);
    chk("rs_frame_st", 32'(d_frame_start), 1);
    tick(2);
    chk("rs_blank", 32'(d_blank), 0);
    tick(7);
    chk("pre_rst_blank",   32'(d_blank), 0);
    chk("pre_rst_pix_req", 32'(d_pix_req), 1);

    // Reset mid active pixel with run held high
    reset = 1'b1;
    tick(1);
    chk("mrst_blank",   32'(d_blank), 1);
    chk("mrst_hsync",   32'(d_h_synch), 1);
    chk("mrst_vsync",   32'(d_v_synch), 1);
    chk("mrst_pix_req", 32'(d_pix_req), 0);
    tick(2);
    chk("mrst_hold_blank", 32'(d_blank), 1);
    reset = 1'b0; cyc = -1;
    blank_ones = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (d_blank === 1'b1) blank_ones = blank_ones + 1;
    end
    chk("mrst_no_unblank", 32'(blank_ones), 3);
    chk("mrst_c2_pix_req", 32'(d_pix_req), 1);
    tick(1);
    chk("mrst_c3_blank", 32'(d_blank), 0);
    run = 1'b0;

    // Whole frame on the small raster
    run_s = 1'b1; cyc = -1;
    tick(1);
    fs_cnt = 0; fs_first = 0; req_cnt = 0; vs_low = 0; vs_first = 0;
    hs_high = 0; blank_low = 0; row = 0;
    for (int i = 0; i < 192; i++) begin
      tick(1);
      if (s_frame_start === 1'b1) begin
        if (fs_cnt == 0) fs_first = cyc;
        fs_cnt = fs_cnt + 1;
      end
      if (s_pix_req === 1'b1) req_cnt = req_cnt + 1;
      if (s_v_synch === 1'b0) begin
        if (vs_low == 0) vs_first = cyc;
        vs_low = vs_low + 1;
      end
      if (s_h_synch === 1'b1) hs_high = hs_high + 1;
      if (s_blank === 1'b0) blank_low = blank_low + 1;
      if (s_pix_req === 1'b1 && s_pix_x == 11'd0) begin
        chk("s_row_pix_y",    32'(s_pix_y), c_sd ? (row >> 1) : row);
        chk("s_row_line_rep", 32'(s_line_repeat), c_sd ? (row & 1) : 0);
        row = row + 1;
      end
    end
    chk("s_frame_cnt",   32'(fs_cnt), 1);
    chk("s_frame_first", 32'(fs_first), 1);
    chk("s_req_cnt",     32'(req_cnt), 48);
    chk("s_vs_low",      32'(vs_low), 32);
    chk("s_vs_first",    32'(vs_first), 132);
    chk("s_hs_high",     32'(hs_high), 36);
    chk("s_blank_low",   32'(blank_low), 48);
    chk("s_rows",        32'(row), 6);
    tick(1);
    chk("s_wrap_frame_st", 32'(s_frame_start), 1);
    chk("s_wrap_pix_req",  32'(s_pix_req), 1);
    chk("s_wrap_pix_x",    32'(s_pix_x), 0);
    chk("s_wrap_pix_y",    32'(s_pix_y), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
